// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: {bout, diff} = a - b - bin, one bit per clock, LSB first.
// Operands are captured on an accepted start; the result is held until the next completion.
module serial_subtractor #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   sr_a_q, sr_a_d;
  logic [WIDTH-1:0]   sr_b_q, sr_b_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               borrow_q, borrow_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   diff_q, diff_d;
  logic               bout_q, bout_d;

  logic               d_bit;
  logic               borrow_nxt;
  logic               last_bit;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sr_a_q   <= '0;
      sr_b_q   <= '0;
      res_q    <= '0;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sr_a_q   <= sr_a_d;
      sr_b_q   <= sr_b_d;
      res_q    <= res_d;
      cnt_q    <= cnt_d;
      borrow_q <= borrow_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
    end
  end

  // Next-state and one full-subtractor bit slice per cycle
  always_comb begin
    state_d    = state_q;
    sr_a_d     = sr_a_q;
    sr_b_d     = sr_b_q;
    res_d      = res_q;
    cnt_d      = cnt_q;
    borrow_d   = borrow_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    diff_d     = diff_q;
    bout_d     = bout_q;

    d_bit      = sr_a_q[0] ^ sr_b_q[0] ^ borrow_q;
    borrow_nxt = (~sr_a_q[0] & sr_b_q[0]) | (~(sr_a_q[0] ^ sr_b_q[0]) & borrow_q);
    last_bit   = (cnt_q == CNT_W'(WIDTH - 1));

    case (state_q)
      IDLE: begin
        if (start) begin
          sr_a_d   = a;
          sr_b_d   = b;
          borrow_d = bin;
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = RUN;
        end
      end
      RUN: begin
        sr_a_d   = sr_a_q >> 1;
        sr_b_d   = sr_b_q >> 1;
        res_d    = {d_bit, res_q[WIDTH-1:1]};
        borrow_d = borrow_nxt;
        cnt_d    = cnt_q + CNT_W'(1);
        // Final bit: publish the assembled result and return to IDLE
        if (last_bit) begin
          diff_d  = res_d;
          bout_d  = borrow_nxt;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial, multi-cycle subtractor computing {bout, diff} = a - b - bin, LSB first, one bit per clock.
- Inverse-direction companion to the team's combinational adder.
- Used to check adder results (diff of sum and operand recovers the other operand) and as a low-area subtract unit.
- Operands are captured on a start handshake. The result is presented with a one-cycle done pulse and held until the next completion.

Parameters:
- WIDTH, 4: operand and difference width in bits (>= 2).
- CNT_W, $clog2(WIDTH)+1: bit-counter width. Derived; do not override.

Ports:
- clk, input, 1: single clock, rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- start, input, 1: request a new subtraction; sampled only when busy=0.
- a, input, WIDTH: minuend, unsigned; captured on the accepted start.
- b, input, WIDTH: subtrahend, unsigned; captured on the accepted start.
- bin, input, 1: borrow-in; captured on the accepted start.
- busy, output, 1: high while an operation is in progress.
- done, output, 1: one-cycle pulse when diff/bout update.
- diff, output, WIDTH: (a - b - bin) mod 2^WIDTH, registered.
- bout, output, 1: borrow-out; 1 iff a < b + bin (unsigned).

Behaviour:
- Reset (rst_n=0, async, at any time including mid-operation): state=IDLE, busy=0, done=0, diff=0, bout=0, all internal shift registers, counter and borrow=0.
  - Any in-flight operation is discarded; no done pulse follows.
  - After release, the first accepted start behaves normally.
- States: IDLE, RUN.
- IDLE:
  - On a clk edge with start=1, latch a, b and bin into internal registers: sr_a, sr_b, borrow=bin, cnt=0.
  - Go to RUN; busy=1 from that edge.
  - start=0: remain in IDLE.
- RUN, each edge processes bit i=cnt:
  - d_i = sr_a[0] ^ sr_b[0] ^ borrow
  - borrow_next = (~sr_a[0] & sr_b[0]) | (~(sr_a[0] ^ sr_b[0]) & borrow)
  - sr_a and sr_b shift right by one.
  - d_i shifts into the MSB of an internal result shift register.
  - cnt increments.
- Completion: on the edge processing bit WIDTH-1:
  - diff <= full result including d_(WIDTH-1); bout <= borrow_next.
  - done=1 for exactly that one cycle; busy=0; state=IDLE.
- Latency: start sampled at edge k, so diff/bout/done are valid after edge k+WIDTH. For WIDTH=4, done is high in the cycle after the 4th edge following acceptance. Throughput is one operation per WIDTH+1 cycles.
- start while busy=1: ignored. Operand registers are not disturbed.
- start while done=1: accepted, because the state is already IDLE; done clears on that edge and busy rises.
- Input changes on a, b or bin after acceptance have no effect on the current operation.
- diff and bout hold their last completed value through IDLE and RUN. They change only on a completion edge or on reset.
- Wrap-around: a negative true result appears as 2^WIDTH + (a - b - bin) with bout=1.
  - Example: 0 - 0 - 1 gives diff=all ones, bout=1.
- No combinational path from inputs to outputs; all outputs are registers.

Test Plan:
- Reset, then a=15, b=3, bin=0, start pulse -> done after exactly 4 edges; diff=12, bout=0; busy high for 4 cycles.
- Back-to-back, start held high across the done cycle:
  - Op 1: a=13, b=2, bin=1 -> diff=10, bout=0.
  - Op 2: a=12, b=5, bin=0 -> diff=7, bout=0.
  - Second done arrives 5 edges after the first.
- a=15, b=15, bin=1 -> diff=15, bout=1. Also a=0, b=0, bin=1 -> diff=15, bout=1 (wrap-around).
- Start a=9, b=4, bin=0, then assert start with a=1, b=1 at edge 2 -> ignored; result diff=5, bout=0; single done pulse.
- Start a=7, b=1, assert rst_n=0 asynchronously mid-RUN -> busy, done, diff and bout go to 0 immediately with no done afterwards. After release, a=6, b=6 -> diff=0, bout=0.
- Exhaustive check against the reference equation a - b - bin for all 512 combinations (WIDTH=4), with a randomized idle gap of 0-3 cycles between operations.
